// File: rtl/oled_pixel_streamer.sv
// Frame-streaming SPI transmitter for the 96x64 RGB565 Pmod OLED.
// Per frame: a 6-byte address-window command header, then every pixel, then a cs-high gap.
// Each SPI bit takes 2 clk cycles (sclk low, then high); all outputs are registered.
module oled_pixel_streamer #(
  parameter int WIDTH     = 96,
  parameter int HEIGHT    = 64,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        sample_pixel,
  output logic [12:0] pixel_index,
  output logic        cs,
  output logic        sdin,
  output logic        sclk,
  output logic        d_cn,
  output logic        busy
);

  localparam logic [7:0]  CMD_FIRST = 8'h15;
  localparam logic [7:0]  COL_END   = 8'(WIDTH - 1);
  localparam logic [7:0]  ROW_END   = 8'(HEIGHT - 1);
  localparam logic [12:0] LAST_PIX  = 13'(WIDTH * HEIGHT - 1);
  localparam int          GW        = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GW-1:0] GAP_END = GW'(FRAME_GAP - 1);

  typedef enum logic [1:0] {IDLE, CMD, PIX, GAP} state_t;

  state_t        state_q;
  logic          half_q;       // 0 = sclk-low half of a bit, 1 = sclk-high half
  logic [3:0]    bit_q;        // bit within the current byte (CMD) or pixel (PIX)
  logic [2:0]    byte_q;       // command byte 0..5
  logic [GW-1:0] gap_q;
  logic [15:0]   shift_q;      // pixel currently being sent
  logic [12:0]   pixel_index_q;
  logic          frame_begin_q, sending_q, sample_q, cs_q, sdin_q, sclk_q, d_cn_q, busy_q;

  logic [7:0] cur_byte;
  logic [7:0] nxt_byte;
  logic       start;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = CMD_FIRST;   // set column address
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = COL_END;
      3'd3:    cmd_byte = 8'h75;       // set row address
      3'd4:    cmd_byte = 8'h00;
      default: cmd_byte = ROW_END;
    endcase
  endfunction

  assign cur_byte = cmd_byte(byte_q);
  assign nxt_byte = cmd_byte(byte_q + 3'd1);

  // A frame starts from IDLE, or back-to-back once the gap has run out, whenever enable is high.
  always_comb begin
    start = 1'b0;
    if (enable && (state_q == IDLE || (state_q == GAP && gap_q == GAP_END))) start = 1'b1;
  end

  // Frame sequencer: advances the bit/byte/pixel counters and registers every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      half_q        <= 1'b0;
      bit_q         <= 4'd0;
      byte_q        <= 3'd0;
      gap_q         <= '0;
      shift_q       <= 16'd0;
      pixel_index_q <= 13'd0;
      frame_begin_q <= 1'b0;
      sending_q     <= 1'b0;
      sample_q      <= 1'b0;
      cs_q          <= 1'b1;
      sdin_q        <= 1'b0;
      sclk_q        <= 1'b1;
      d_cn_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_begin_q <= 1'b0;
      sample_q      <= 1'b0;
      if (start) begin
        state_q       <= CMD;
        half_q        <= 1'b0;
        bit_q         <= 4'd0;
        byte_q        <= 3'd0;
        pixel_index_q <= 13'd0;
        frame_begin_q <= 1'b1;
        cs_q          <= 1'b0;
        sclk_q        <= 1'b0;
        sdin_q        <= CMD_FIRST[7];
        d_cn_q        <= 1'b0;
        busy_q        <= 1'b1;
      end else begin
        case (state_q)
          CMD: begin
            if (!half_q) begin
              half_q <= 1'b1;
              sclk_q <= 1'b1;
              // The header's final cycle doubles as the capture cycle for pixel 0.
              if (byte_q == 3'd5 && bit_q == 4'd7) sample_q <= 1'b1;
            end else if (bit_q != 4'd7) begin
              bit_q  <= bit_q + 4'd1;
              half_q <= 1'b0;
              sclk_q <= 1'b0;
              sdin_q <= cur_byte[3'd6 - bit_q[2:0]];
            end else if (byte_q != 3'd5) begin
              byte_q <= byte_q + 3'd1;
              bit_q  <= 4'd0;
              half_q <= 1'b0;
              sclk_q <= 1'b0;
              sdin_q <= nxt_byte[7];
            end else begin
              state_q   <= PIX;
              shift_q   <= pixel_data;
              sdin_q    <= pixel_data[15];
              bit_q     <= 4'd0;
              half_q    <= 1'b0;
              sclk_q    <= 1'b0;
              d_cn_q    <= 1'b1;
              sending_q <= 1'b1;
            end
          end
          PIX: begin
            if (!half_q) begin
              half_q <= 1'b1;
              sclk_q <= 1'b1;
              // Advance the index at the start of a pixel's last cycle so the source has a full cycle.
              if (bit_q == 4'd15 && pixel_index_q != LAST_PIX) begin
                sample_q      <= 1'b1;
                pixel_index_q <= pixel_index_q + 13'd1;
              end
            end else if (bit_q != 4'd15) begin
              bit_q  <= bit_q + 4'd1;
              half_q <= 1'b0;
              sclk_q <= 1'b0;
              sdin_q <= shift_q[4'd14 - bit_q];
            end else if (sample_q) begin
              shift_q <= pixel_data;
              sdin_q  <= pixel_data[15];
              bit_q   <= 4'd0;
              half_q  <= 1'b0;
              sclk_q  <= 1'b0;
            end else begin
              state_q   <= GAP;
              gap_q     <= '0;
              cs_q      <= 1'b1;
              sclk_q    <= 1'b1;
              sdin_q    <= 1'b0;
              d_cn_q    <= 1'b0;
              sending_q <= 1'b0;
            end
          end
          GAP: begin
            if (gap_q == GAP_END) begin
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              pixel_index_q <= 13'd0;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign frame_begin    = frame_begin_q;
  assign sending_pixels = sending_q;
  assign sample_pixel   = sample_q;
  assign pixel_index    = pixel_index_q;
  assign cs             = cs_q;
  assign sdin           = sdin_q;
  assign sclk           = sclk_q;
  assign d_cn           = d_cn_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer on a reduced 8x4 panel (32 pixels, 1136-cycle frame).
// Decodes the SPI stream on sclk rising edges and checks header, pixels, timing, enable drop and reset.
module tb_oled_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset, enable, const_mode;
  logic [15:0] pixel_data;
  logic        frame_begin, sending_pixels, sample_pixel, cs, sdin, sclk, d_cn, busy;
  logic [12:0] pixel_index;

  int tests = 0;
  int fails = 0;

  // stream observation state
  int          cyc = 0;
  logic        prev_sclk = 1'b1, prev_cs = 1'b1;
  int          cmd_n, pix_n, samp_n, samp_bad, sp_cyc, first_samp_off, last_samp_cyc;
  int          fb_n = 0, fb_cyc = 0, fb_gap = 0, cs_run = 0, last_cs_run = 0, toggle_err = 0;
  logic [47:0] cmd_w;
  logic [15:0] pix_sr;
  logic [15:0] pix_q[$];

  always #5 clk = ~clk;

  assign pixel_data = const_mode ? 16'hF81F : {3'b000, pixel_index};

  oled_pixel_streamer #(.WIDTH(8), .HEIGHT(4), .FRAME_GAP(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pixel_data(pixel_data),
    .frame_begin(frame_begin), .sending_pixels(sending_pixels), .sample_pixel(sample_pixel),
    .pixel_index(pixel_index), .cs(cs), .sdin(sdin), .sclk(sclk), .d_cn(d_cn), .busy(busy)
  );

  task automatic clear_obs();
    cmd_n = 0; cmd_w = '0; pix_n = 0; pix_sr = '0; pix_q.delete();
    samp_n = 0; samp_bad = 0; sp_cyc = 0; first_samp_off = -1; last_samp_cyc = 0;
  endtask

  // advance one cycle and record what the panel would see
  task automatic step();
    @(negedge clk);
    cyc++;
    if (cs) cs_run++;
    else begin
      if (cs_run > 0) last_cs_run = cs_run;
      cs_run = 0;
    end
    if (cs && prev_cs && (sclk !== prev_sclk)) toggle_err++;
    if (!cs && sclk && !prev_sclk) begin
      if (!d_cn) begin
        cmd_n++;
        cmd_w = {cmd_w[46:0], sdin};
      end else begin
        pix_n++;
        pix_sr = {pix_sr[14:0], sdin};
        if (pix_n % 16 == 0) pix_q.push_back(pix_sr);
      end
    end
    if (frame_begin) begin
      if (fb_n > 0) fb_gap = cyc - fb_cyc;
      fb_n++;
      fb_cyc = cyc;
    end
    if (sample_pixel) begin
      if (samp_n == 0) first_samp_off = cyc - fb_cyc;
      else if (cyc - last_samp_cyc != 32) samp_bad++;
      samp_n++;
      last_samp_cyc = cyc;
    end
    if (sending_pixels) sp_cyc++;
    prev_sclk = sclk;
    prev_cs   = cs;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; const_mode = 1'b0;
    clear_obs();
    repeat (3) step();
    tests++;
    if ({cs, sclk, sdin, d_cn, frame_begin, sending_pixels, sample_pixel, busy, pixel_index} !==
        {8'b1100_0000, 13'd0}) begin
      fails++;
      $display("FAIL reset_values: got cs=%b sclk=%b sdin=%b d_cn=%b fb=%b sp=%b smp=%b busy=%b idx=%0d, want 1 1 0 0 0 0 0 0 0",
               cs, sclk, sdin, d_cn, frame_begin, sending_pixels, sample_pixel, busy, pixel_index);
    end
    reset = 1'b0;
    repeat (5) step();
    tests++;
    if (busy !== 1'b0 || cs !== 1'b1 || sclk !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: got busy=%b cs=%b sclk=%b, want 0 1 1", busy, cs, sclk);
    end
  endtask

  task automatic test_header();
    clear_obs();
    enable = 1'b1;
    step();
    tests++;
    if (frame_begin !== 1'b1 || cs !== 1'b0 || busy !== 1'b1 || d_cn !== 1'b0) begin
      fails++;
      $display("FAIL fb_latency: got fb=%b cs=%b busy=%b d_cn=%b, want 1 0 1 0", frame_begin, cs, busy, d_cn);
    end
    for (int i = 0; i < 200 && d_cn !== 1'b1; i++) step();
    tests++;
    if (d_cn !== 1'b1) begin
      fails++;
      $display("FAIL header_timeout: d_cn=%b, want 1 within 200 cycles", d_cn);
    end
    tests++;
    if (cmd_w !== 48'h15_00_07_75_00_03) begin
      fails++;
      $display("FAIL header_bytes: got %h, want 150007750003", cmd_w);
    end
    tests++;
    if (cmd_n !== 48) begin
      fails++;
      $display("FAIL header_edges: got %0d, want 48", cmd_n);
    end
    tests++;
    if (first_samp_off !== 95) begin
      fails++;
      $display("FAIL first_sample: got offset %0d, want 95", first_samp_off);
    end
  endtask

  task automatic test_ramp();
    int bad = 0;
    for (int i = 0; i < 2000 && cs !== 1'b1; i++) step();
    tests++;
    if (cs !== 1'b1 || sclk !== 1'b1 || d_cn !== 1'b0 || sending_pixels !== 1'b0) begin
      fails++;
      $display("FAIL gap_entry: got cs=%b sclk=%b d_cn=%b sp=%b, want 1 1 0 0", cs, sclk, d_cn, sending_pixels);
    end
    tests++;
    if (pix_q.size() !== 32) begin
      fails++;
      $display("FAIL ramp_count: got %0d words, want 32", pix_q.size());
    end
    foreach (pix_q[k]) if (pix_q[k] !== 16'(k)) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL ramp_words: got %0d wrong words, want 0", bad);
    end
    tests++;
    if (samp_n !== 32 || samp_bad !== 0) begin
      fails++;
      $display("FAIL sample_pulses: got %0d pulses, %0d bad spacings, want 32 and 0", samp_n, samp_bad);
    end
    tests++;
    if (pixel_index !== 13'd31) begin
      fails++;
      $display("FAIL end_index: got %0d, want 31", pixel_index);
    end
    tests++;
    if (sp_cyc !== 1024) begin
      fails++;
      $display("FAIL ramp_sending: got %0d cycles, want 1024", sp_cyc);
    end
  endtask

  task automatic test_back_to_back();
    const_mode = 1'b1;
    for (int i = 0; i < 100 && frame_begin !== 1'b1; i++) step();
    tests++;
    if (frame_begin !== 1'b1 || fb_gap !== 1136) begin
      fails++;
      $display("FAIL frame_period: got fb=%b period %0d, want 1 and 1136", frame_begin, fb_gap);
    end
    tests++;
    if (last_cs_run !== 16) begin
      fails++;
      $display("FAIL gap_len: got cs high %0d cycles, want 16", last_cs_run);
    end
  endtask

  task automatic test_constant();
    int bad = 0;
    clear_obs();
    for (int i = 0; i < 2000 && cs !== 1'b1; i++) step();
    foreach (pix_q[k]) if (pix_q[k] !== 16'hF81F) bad++;
    tests++;
    if (pix_q.size() !== 32 || bad !== 0) begin
      fails++;
      $display("FAIL const_words: got %0d words, %0d wrong, want 32 and 0", pix_q.size(), bad);
    end
    tests++;
    if (sp_cyc !== 1024) begin
      fails++;
      $display("FAIL const_sending: got %0d cycles, want 1024", sp_cyc);
    end
    const_mode = 1'b0;
  endtask

  task automatic test_enable_drop();
    int fb_before;
    for (int i = 0; i < 100 && frame_begin !== 1'b1; i++) step();
    clear_obs();
    for (int i = 0; i < 1000 && pixel_index !== 13'd10; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 2000 && busy !== 1'b0; i++) step();
    tests++;
    if (pix_q.size() !== 32 || pix_q[31] !== 16'd31) begin
      fails++;
      $display("FAIL drop_complete: got %0d words, last %h, want 32 and 001f",
               pix_q.size(), (pix_q.size() > 0) ? pix_q[pix_q.size()-1] : 16'hxxxx);
    end
    tests++;
    if (busy !== 1'b0 || pixel_index !== 13'd0 || cs !== 1'b1 || cs_run !== 17) begin
      fails++;
      $display("FAIL drop_idle: got busy=%b idx=%0d cs=%b cs_run=%0d, want 0 0 1 17", busy, pixel_index, cs, cs_run);
    end
    fb_before = fb_n;
    repeat (200) step();
    tests++;
    if (fb_n !== fb_before || busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_no_frame: got %0d extra frame_begin, busy=%b, want 0 and 0", fb_n - fb_before, busy);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    for (int i = 0; i < 10 && frame_begin !== 1'b1; i++) step();
    for (int i = 0; i < 1000 && pixel_index !== 13'd15; i++) step();
    tests++;
    if (pixel_index !== 13'd15 || sending_pixels !== 1'b1) begin
      fails++;
      $display("FAIL mid_reach: got idx=%0d sp=%b, want 15 and 1", pixel_index, sending_pixels);
    end
    reset = 1'b1;
    step();
    tests++;
    if ({cs, sclk, busy, sending_pixels, sample_pixel, d_cn} !== 6'b110000) begin
      fails++;
      $display("FAIL mid_reset: got cs=%b sclk=%b busy=%b sp=%b smp=%b d_cn=%b, want 1 1 0 0 0 0",
               cs, sclk, busy, sending_pixels, sample_pixel, d_cn);
    end
    step();
    reset = 1'b0;
    step();
    tests++;
    if (frame_begin !== 1'b1 || cs !== 1'b0) begin
      fails++;
      $display("FAIL restart: got fb=%b cs=%b, want 1 0", frame_begin, cs);
    end
    tests++;
    if (toggle_err !== 0) begin
      fails++;
      $display("FAIL sclk_quiet: got %0d toggles with cs high, want 0", toggle_err);
    end
  endtask

  initial begin
    test_reset();
    test_header();
    test_ramp();
    test_back_to_back();
    test_constant();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oled_pixel_streamer.md
# oled_pixel_streamer

Frame-streaming SPI transmitter for the 96x64 16-bit-colour Pmod OLED. It pulls pixels from a combinational pixel source (the bar renderers) through the pixel_index / sample_pixel interface and serialises them to the panel. Each frame it sends an address-window command header, then all 6144 pixels. The block sits between the visualisation logic and the Pmod connector. Panel power-up and initialisation happen before enable is raised and are outside this block.

## Interface
- WIDTH, 96: pixels per row.
- HEIGHT, 64: rows per frame.
- FRAME_GAP, 16: clk cycles with cs high between frames.
- clk  in  1  display clock (6.25 MHz domain).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; high = stream frames continuously.
- pixel_data  in  16  RGB565 colour for the current pixel_index (combinational from source).
- frame_begin  out  1  one-cycle pulse at the start of each frame.
- sending_pixels  out  1  high throughout the pixel phase.
- sample_pixel  out  1  one-cycle pulse; pixel_data is captured at the end of this cycle.
- pixel_index  out  13  current pixel, row-major: y*WIDTH + x.
- cs  out  1  SPI chip select, active low.
- sdin  out  1  SPI data, MSB first.
- sclk  out  1  SPI clock, idles high.
- d_cn  out  1  0 = command byte, 1 = pixel data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Reset values: cs=1, sclk=1, sdin=0, d_cn=0, frame_begin=0, sending_pixels=0, sample_pixel=0, pixel_index=0, busy=0; state IDLE.
- States: IDLE, CMD, PIX, GAP.
- IDLE -> CMD when enable=1.
- CMD:
  - sends 6 bytes with d_cn=0: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1.
  - frame_begin pulses in the first CMD cycle.
  - cs goes low in the first CMD cycle and stays low through the end of PIX.
- Bit encoding:
  - each bit occupies 2 clk cycles.
  - cycle A: sclk=0, sdin takes the new bit.
  - cycle B: sclk=1; the panel samples on this rising edge.
  - one byte = 16 cycles.
- CMD -> PIX:
  - sample_pixel pulses in the last cycle of the last command byte, with pixel_index=0.
  - the 16-bit shift register loads pixel_data on that edge.
- PIX:
  - d_cn=1 and sending_pixels=1 for the whole phase.
  - each pixel = 16 bits = 32 cycles, sent MSB first.
  - in the last cycle of pixel n (n < WIDTH*HEIGHT-1), pixel_index becomes n+1 and sample_pixel pulses; pixel_index then holds until the next sample.
- PIX -> GAP after the last bit of pixel 6143. In GAP: cs=1, sclk=1, sending_pixels=0, d_cn=0.
- GAP lasts FRAME_GAP cycles, then:
  - -> CMD if enable=1;
  - -> IDLE otherwise, with pixel_index reset to 0.
- enable falling mid-frame: the current frame completes, then the block goes to IDLE after GAP.
- reset mid-frame: the next cycle shows reset values and the frame is abandoned. cs rises immediately.
- Counters:
  - bit counter 0..15;
  - byte counter 0..5;
  - pixel counter 13 bits, wraps to 0 only at frame start;
  - gap counter sized to FRAME_GAP.

## Timing
- CMD phase: 96 cycles. PIX phase: 6144*32 = 196608 cycles. Frame period: 196704 + FRAME_GAP = 196720 cycles at defaults.
- Latency from enable rising in IDLE: frame_begin=1 on the following cycle.
- pixel_data is sampled exactly once per pixel, on the clock edge ending the sample_pixel cycle. The source has one full cycle of pixel_index stability before the capture.
- Consecutive sample_pixel pulses are 32 cycles apart. The first arrives 95 cycles after frame_begin.
- sclk never toggles while cs=1.

## Test plan
- Reset then enable=1 -> frame_begin at cycle 1; sdin bytes decode to 0x15,0x00,0x5F,0x75,0x00,0x3F with d_cn=0; sclk has exactly 48 rising edges before d_cn rises.
- Pixel source returns pixel_data = {3'b0, pixel_index} -> the decoded stream gives pixel k equal to k for k = 0..6143; sample_pixel count per frame = 6144; pixel_index ends at 6143.
- Constant pixel_data=0xF81F -> every 16-bit word after the header equals 0xF81F; sending_pixels is high for exactly 196608 cycles.
- enable held high -> frame_begin pulses are 196720 cycles apart; cs is high for exactly 16 cycles between frames.
- enable dropped at pixel 100 -> frame completes through pixel 6143; after GAP the block is in IDLE with busy=0 and pixel_index=0; no second frame_begin.
- reset asserted at pixel 3000 -> next cycle cs=1, sclk=1, busy=0, sending_pixels=0; with enable still high, a new frame_begin follows reset release by 1 cycle.
